// File: rtl/mmm_exp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mmm_exp_ctrl_pkg
// Shared definitions for the modular-exponentiation controller:
//   - default widths and multiplier step count
//   - top-level FSM state codes (one Montgomery multiplication per op state)
//   - per-multiplication phase codes used by the op sequencer
// ----------------------------------------------------------------------------
package mmm_exp_ctrl_pkg;

    localparam int DEF_WIDTH      = 10;
    localparam int DEF_EXP_WIDTH  = 10;
    // WIDTH bit-steps plus two flush cycles inside the multiplier
    localparam int DEF_MMM_CYCLES = 12;

    // Top FSM
    typedef logic [2:0] state_t;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE_X = 3'd1;   // xbar = MMM(base, r2)
    localparam logic [2:0] ST_PRE_A = 3'd2;   // acc  = MMM(1, r2)
    localparam logic [2:0] ST_SQR   = 3'd3;   // acc  = MMM(acc, acc)
    localparam logic [2:0] ST_MUL   = 3'd4;   // acc  = MMM(acc, xbar)
    localparam logic [2:0] ST_POST  = 3'd5;   // result = MMM(acc, 1)
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Phases of a single multiplication
    typedef logic [1:0] phase_t;
    localparam logic [1:0] PH_CLR  = 2'd0;    // clear accumulator, load A
    localparam logic [1:0] PH_RUN  = 2'd1;    // MMM_CYCLES enable pulses
    localparam logic [1:0] PH_CAPT = 2'd2;    // capture multiplier result
    localparam logic [1:0] PH_WB   = 2'd3;    // write result to destination

endpackage

// File: rtl/mmm_exp_ctrl_if.sv
// ----------------------------------------------------------------------------
// mmm_exp_ctrl_if
// Bundles the register-file request side and the Montgomery multiplier side
// of the exponentiation controller.
//   slave  : view of the controller (takes requests, drives the multiplier)
//   master : view of the environment (register file + multiplier instance)
// Signals:
//   start/base/exponent/modulus/r2_mod  request and operands
//   busy/done/result                    status and final value
//   mmm_en/mmm_rst/mmm_ld_a/mmm_ld_r/mmm_lock, mmm_a/mmm_b/mmm_m  multiplier drive
//   mmm_r                               multiplier result
// ----------------------------------------------------------------------------
interface mmm_exp_ctrl_if #(
    parameter int WIDTH     = 10,
    parameter int EXP_WIDTH = 10
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     r2_mod;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 mmm_en;
    logic                 mmm_rst;
    logic                 mmm_ld_a;
    logic                 mmm_ld_r;
    logic                 mmm_lock;
    logic [WIDTH-1:0]     mmm_a;
    logic [WIDTH-1:0]     mmm_b;
    logic [WIDTH-1:0]     mmm_m;
    logic [WIDTH-1:0]     mmm_r;

    modport slave (
        input  start, base, exponent, modulus, r2_mod, mmm_r,
        output busy, done, result,
        output mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock,
        output mmm_a, mmm_b, mmm_m
    );

    modport master (
        output start, base, exponent, modulus, r2_mod, mmm_r,
        input  busy, done, result,
        input  mmm_en, mmm_rst, mmm_ld_a, mmm_ld_r, mmm_lock,
        input  mmm_a, mmm_b, mmm_m
    );
endinterface

// File: rtl/mmm_exp_ctrl_op_seq.sv
// ----------------------------------------------------------------------------
// mmm_op_seq
// Runs one Montgomery multiplication: CLR (1) -> RUN (MMM_CYCLES) -> CAPT (1)
// -> WB (1). A new op_go may arrive during WB so ops run back to back.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_op_go       start a multiplication (CLR next cycle)
//   o_op_done     high during WB; destination register is written at its end
//   o_mmm_en      multiplier step enable (RUN)
//   o_mmm_rst     accumulator clear (CLR)
//   o_mmm_ld_a    A shift-register load (CLR)
//   o_mmm_ld_r    result capture (CAPT)
//   o_mmm_lock    result freeze, low only in CAPT
// ----------------------------------------------------------------------------
module mmm_op_seq
    import mmm_exp_ctrl_pkg::*;
#(
    parameter int MMM_CYCLES = DEF_MMM_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_op_go,
    output logic o_op_done,
    output logic o_mmm_en,
    output logic o_mmm_rst,
    output logic o_mmm_ld_a,
    output logic o_mmm_ld_r,
    output logic o_mmm_lock
);

    localparam int CNT_W = (MMM_CYCLES > 1) ? $clog2(MMM_CYCLES) : 1;

    logic             r_active;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_phase  <= PH_CLR;
            r_cnt    <= '0;
        end else if (i_op_go) begin
            // op_go wins over WB so the next op starts without a gap
            r_active <= 1'b1;
            r_phase  <= PH_CLR;
            r_cnt    <= '0;
        end else if (r_active) begin
            case (r_phase)
                PH_CLR: begin
                    r_phase <= PH_RUN;
                    r_cnt   <= '0;
                end
                PH_RUN: begin
                    if (r_cnt == CNT_W'(MMM_CYCLES - 1)) begin
                        r_phase <= PH_CAPT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_CAPT: r_phase <= PH_WB;
                default: r_active <= 1'b0;   // PH_WB, no follow-on op
            endcase
        end
    end

    assign o_op_done  = r_active && (r_phase == PH_WB);
    assign o_mmm_en   = r_active && (r_phase == PH_RUN);
    assign o_mmm_rst  = r_active && (r_phase == PH_CLR);
    assign o_mmm_ld_a = r_active && (r_phase == PH_CLR);
    assign o_mmm_ld_r = r_active && (r_phase == PH_CAPT);
    assign o_mmm_lock = !(r_active && (r_phase == PH_CAPT));

endmodule

// File: rtl/mmm_exp_ctrl.sv
// ----------------------------------------------------------------------------
// mmm_exp_ctrl
// Computes result = base^exponent mod modulus with left-to-right
// square-and-multiply in the Montgomery domain, sequencing one external
// bit-serial Montgomery multiplier.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   mmm_exp_ctrl_if.slave: request/operands in, busy/done/result out,
//         multiplier strobes and A/B/M operands out, multiplier result in
// ----------------------------------------------------------------------------
module mmm_exp_ctrl
    import mmm_exp_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int MMM_CYCLES = DEF_MMM_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    mmm_exp_ctrl_if.slave bus
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_next;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_r2;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_xbar;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_a_next;
    logic [WIDTH-1:0]     w_b_next;
    logic [WIDTH-1:0]     w_acc_fwd;
    logic                 w_start_acc;
    logic                 w_op_go;
    logic                 w_op_done;
    logic                 w_writes_acc;
    logic                 w_last_bit;
    logic                 w_mmm_en;
    logic                 w_mmm_rst;
    logic                 w_mmm_ld_a;
    logic                 w_mmm_ld_r;
    logic                 w_mmm_lock;

    assign w_start_acc  = (r_state == ST_IDLE) && bus.start;
    assign w_last_bit   = (r_idx == '0);
    assign w_writes_acc = (r_state == ST_PRE_A) || (r_state == ST_SQR) || (r_state == ST_MUL);

    // The next op's operands are loaded on the same edge that writes acc,
    // so take the multiplier output directly when acc is being updated.
    assign w_acc_fwd = (w_op_done && w_writes_acc) ? bus.mmm_r : r_acc;

    // ------------------------------------------------------------------
    // Next state / bit index / op launch
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_op_go      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_PRE_X;
                    w_idx_next   = IDX_W'(EXP_WIDTH - 1);
                    w_op_go      = 1'b1;
                end
            end
            ST_PRE_X: begin
                if (w_op_done) begin
                    w_state_next = ST_PRE_A;
                    w_op_go      = 1'b1;
                end
            end
            ST_PRE_A: begin
                if (w_op_done) begin
                    // A zero exponent needs no squarings: acc already holds
                    // the Montgomery form of 1.
                    w_state_next = (r_exp == '0) ? ST_POST : ST_SQR;
                    w_op_go      = 1'b1;
                end
            end
            ST_SQR: begin
                if (w_op_done) begin
                    w_op_go = 1'b1;
                    if (r_exp[r_idx]) begin
                        w_state_next = ST_MUL;
                    end else if (w_last_bit) begin
                        w_state_next = ST_POST;
                    end else begin
                        w_state_next = ST_SQR;
                        w_idx_next   = r_idx - 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_op_done) begin
                    w_op_go = 1'b1;
                    if (w_last_bit) begin
                        w_state_next = ST_POST;
                    end else begin
                        w_state_next = ST_SQR;
                        w_idx_next   = r_idx - 1'b1;
                    end
                end
            end
            ST_POST: begin
                if (w_op_done) begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                // ST_DONE and any unused code return to IDLE
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // A/B operand selection for the op being launched
    // ------------------------------------------------------------------
    always_comb begin
        w_a_next = r_a;
        w_b_next = r_b;
        if (w_op_go) begin
            case (w_state_next)
                ST_PRE_X: begin
                    w_a_next = bus.base;
                    w_b_next = bus.r2_mod;
                end
                ST_PRE_A: begin
                    w_a_next = WIDTH'(1);
                    w_b_next = r_r2;
                end
                ST_SQR: begin
                    w_a_next = w_acc_fwd;
                    w_b_next = w_acc_fwd;
                end
                ST_MUL: begin
                    w_a_next = w_acc_fwd;
                    w_b_next = r_xbar;
                end
                ST_POST: begin
                    w_a_next = w_acc_fwd;
                    w_b_next = WIDTH'(1);
                end
                default: begin
                    w_a_next = r_a;
                    w_b_next = r_b;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_r2     <= '0;
            r_acc    <= '0;
            r_xbar   <= '0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;

            // Operands are captured once; later input changes are ignored
            if (w_start_acc) begin
                r_exp <= bus.exponent;
                r_mod <= bus.modulus;
                r_r2  <= bus.r2_mod;
            end

            if (w_op_done) begin
                case (r_state)
                    ST_PRE_X:                  r_xbar   <= bus.mmm_r;
                    ST_PRE_A, ST_SQR, ST_MUL:  r_acc    <= bus.mmm_r;
                    ST_POST:                   r_result <= bus.mmm_r;
                    default: ;
                endcase
            end

            // done is registered off the DONE state, so it lands in the
            // following IDLE cycle where a new start may already be taken
            r_done <= (r_state == ST_DONE);

            if (w_start_acc) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiplication phase sequencer
    // ------------------------------------------------------------------
    mmm_op_seq #(
        .MMM_CYCLES (MMM_CYCLES)
    ) u_op_seq (
        .clk        (clk),
        .rst        (rst),
        .i_op_go    (w_op_go),
        .o_op_done  (w_op_done),
        .o_mmm_en   (w_mmm_en),
        .o_mmm_rst  (w_mmm_rst),
        .o_mmm_ld_a (w_mmm_ld_a),
        .o_mmm_ld_r (w_mmm_ld_r),
        .o_mmm_lock (w_mmm_lock)
    );

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.mmm_en   = w_mmm_en;
    assign bus.mmm_rst  = w_mmm_rst;
    assign bus.mmm_ld_a = w_mmm_ld_a;
    assign bus.mmm_ld_r = w_mmm_ld_r;
    assign bus.mmm_lock = w_mmm_lock;
    assign bus.mmm_a    = r_a;
    assign bus.mmm_b    = r_b;
    assign bus.mmm_m    = r_mod;

endmodule

// File: tb/tb_mmm_exp_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mmm_exp_ctrl
// Self-checking bench for mmm_exp_ctrl. A behavioural Montgomery multiplier
// answers the controller; results are compared against plain modular
// exponentiation and latencies against the op-count rule.
// ----------------------------------------------------------------------------
module tb_mmm_exp_ctrl;

    localparam int W     = 10;
    localparam int EW    = 10;
    localparam int NCYC  = 12;
    localparam int OPC   = NCYC + 3;
    localparam int LIMIT = 1000;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mmm_exp_ctrl_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

    mmm_exp_ctrl #(
        .WIDTH      (W),
        .EXP_WIDTH  (EW),
        .MMM_CYCLES (NCYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] m);
        logic [31:0] t;
        t = 32'(a) * 32'(b);
        for (int i = 0; i < W; i++) begin
            if (t[0]) t = t + 32'(m);
            t = t >> 1;
        end
        if (t >= 32'(m)) t = t - 32'(m);
        return t[W-1:0];
    endfunction

    function automatic int unsigned modpow(input int unsigned b, input int unsigned e,
                                           input int unsigned m);
        int unsigned r;
        int unsigned x;
        r = 1 % m;
        x = b % m;
        for (int i = 0; i < EW; i++) begin
            if (((e >> i) & 1) != 0) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [EW-1:0] e);
        int ops;
        ops = (e == '0) ? 3 : (3 + EW + $countones(e));
        return ops * OPC + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural Montgomery multiplier: result valid only if CLR loaded
    // the operands, exactly NCYC enables followed with A/B stable.
    // ------------------------------------------------------------------
    logic [W-1:0] cap_a, cap_b, cap_m;
    int           en_cnt;
    bit           cap_ok;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_a     <= '0;
            cap_b     <= '0;
            cap_m     <= '0;
            en_cnt    <= 0;
            cap_ok    <= 1'b0;
            bus.mmm_r <= '0;
        end else begin
            if (bus.mmm_rst && bus.mmm_ld_a) begin
                cap_a  <= bus.mmm_a;
                cap_b  <= bus.mmm_b;
                cap_m  <= bus.mmm_m;
                en_cnt <= 0;
                cap_ok <= 1'b1;
            end else if (bus.mmm_en) begin
                en_cnt <= en_cnt + 1;
                if (bus.mmm_a !== cap_a || bus.mmm_b !== cap_b) cap_ok <= 1'b0;
            end
            if (bus.mmm_ld_r && !bus.mmm_lock) begin
                if (cap_ok && en_cnt == NCYC) bus.mmm_r <= mont(cap_a, cap_b, cap_m);
                else                          bus.mmm_r <= 10'h2AA;
                cap_ok <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One exponentiation, with per-run observations
    // ------------------------------------------------------------------
    logic [W-1:0] g_res;
    int           g_lat, g_clr, g_en, g_capt, g_lock0, g_bx;
    bit           g_busy_ok, g_timeout;

    task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] m, input int restart_at, input bit immediate);
        int k;
        logic [W-1:0] xb;
        xb = W'((32'(b) * 1024) % 32'(m));
        if (!immediate) @(negedge clk);
        bus.start    = 1'b1;
        bus.base     = b;
        bus.exponent = e;
        bus.modulus  = m;
        bus.r2_mod   = W'((32'd1 << 20) % 32'(m));
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; g_clr = 0; g_en = 0; g_capt = 0; g_lock0 = 0; g_bx = 0; g_busy_ok = 1'b1;
        while (bus.done !== 1'b1 && k < LIMIT) begin
            if (bus.busy !== 1'b1) g_busy_ok = 1'b0;
            if (bus.mmm_rst && bus.mmm_ld_a) begin
                if (g_clr > 0 && bus.mmm_b == xb) g_bx++;
                g_clr++;
            end
            if (bus.mmm_en) g_en++;
            if (bus.mmm_ld_r && !bus.mmm_lock) g_capt++;
            if (!bus.mmm_lock) g_lock0++;
            @(negedge clk);
            k++;
            if (k == restart_at) begin
                bus.start    = 1'b1;
                bus.base     = 7;
                bus.exponent = 0;
            end else begin
                bus.start = 1'b0;
            end
        end
        g_lat     = k;
        g_res     = bus.result;
        g_timeout = (k >= LIMIT);
    endtask

    typedef struct {
        logic [W-1:0]  base;
        logic [EW-1:0] expo;
        logic [W-1:0]  modu;
        logic [W-1:0]  res;
        int            lat;
        bit            nomul;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ops;
        int extra_done;
        logic [W-1:0]  rb, rm;
        logic [EW-1:0] re;

        vecs[0] = '{base: 5,  expo: 3,     modu: 23,   res: 10, lat: 226, nomul: 0};
        vecs[1] = '{base: 7,  expo: 0,     modu: 23,   res: 1,  lat: 46,  nomul: 1};
        vecs[2] = '{base: 2,  expo: 11,    modu: 23,   res: 1,  lat: 241, nomul: 0};
        vecs[3] = '{base: 0,  expo: 5,     modu: 23,   res: 0,  lat: 226, nomul: 0};
        vecs[4] = '{base: 22, expo: 10'h3FF, modu: 23, res: 22, lat: 346, nomul: 0};
        vecs[5] = '{base: 3,  expo: 6,     modu: 7,    res: 1,  lat: 226, nomul: 0};
        vecs[6] = '{base: 1,  expo: 10'h3FF, modu: 1023, res: 1, lat: 346, nomul: 0};
        vecs[7] = '{base: 0,  expo: 0,     modu: 23,   res: 1,  lat: 46,  nomul: 1};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.base     = '0;
        bus.exponent = '0;
        bus.modulus  = '0;
        bus.r2_mod   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_en",    bus.mmm_en, 0);
        check("rst_mrst",  bus.mmm_rst, 0);
        check("rst_lda",   bus.mmm_ld_a, 0);
        check("rst_ldr",   bus.mmm_ld_r, 0);
        check("rst_lock",  bus.mmm_lock, 1);
        check("rst_res",   bus.result, 0);
        check("rst_a",     bus.mmm_a, 0);
        check("rst_b",     bus.mmm_b, 0);
        check("rst_m",     bus.mmm_m, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].base, vecs[i].expo, vecs[i].modu, -1, 1'b0);
            ops = (vecs[i].lat - 1) / OPC;
            $display("vec%0d: base=%0d exp=%0d mod=%0d -> result=%0d latency=%0d",
                     i, vecs[i].base, vecs[i].expo, vecs[i].modu, g_res, g_lat);
            check($sformatf("vec%0d_timeout", i), g_timeout, 0);
            check($sformatf("vec%0d_result", i), g_res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), g_lat, vecs[i].lat);
            check($sformatf("vec%0d_busy_held", i), g_busy_ok, 1);
            check($sformatf("vec%0d_clr_count", i), g_clr, ops);
            check($sformatf("vec%0d_en_count", i), g_en, ops * NCYC);
            check($sformatf("vec%0d_capt_count", i), g_capt, ops);
            check($sformatf("vec%0d_unlock_count", i), g_lock0, ops);
            if (vecs[i].nomul) check($sformatf("vec%0d_no_mul_op", i), g_bx, 0);
        end

        // start in the IDLE cycle that carries done: accepted immediately
        run_op(5, 3, 23, -1, 1'b1);
        $display("back-to-back: result=%0d latency=%0d", g_res, g_lat);
        check("b2b_result", g_res, 10);
        check("b2b_latency", g_lat, 226);

        // start pulsed mid-run with new operands: ignored, single done
        run_op(5, 3, 23, 50, 1'b0);
        extra_done = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
            if (bus.busy === 1'b1) extra_done++;
        end
        $display("restart-ignored: result=%0d latency=%0d extra=%0d", g_res, g_lat, extra_done);
        check("restart_result", g_res, 10);
        check("restart_latency", g_lat, 226);
        check("restart_no_second_run", extra_done, 0);
        check("restart_result_held", bus.result, 10);

        // Reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1; bus.base = 5; bus.exponent = 3; bus.modulus = 23; bus.r2_mod = 6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        check("midrun_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy_async", bus.busy, 0);
        check("midrst_en_async", bus.mmm_en, 0);
        check("midrst_lock_async", bus.mmm_lock, 1);
        @(posedge clk);
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_en", bus.mmm_en, 0);
        check("midrst_lock", bus.mmm_lock, 1);
        check("midrst_result", bus.result, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(5, 3, 23, -1, 1'b0);
        $display("after-reset: result=%0d latency=%0d", g_res, g_lat);
        check("postrst_timeout", g_timeout, 0);
        check("postrst_result", g_res, 10);
        check("postrst_latency", g_lat, 226);

        // Randomized runs against plain modular exponentiation
        for (int i = 0; i < 200; i++) begin
            rm = W'(2 * $urandom_range(1, 511) + 1);
            rb = W'($urandom_range(0, 32'(rm) - 1));
            if (i % 20 == 0)      re = 10'h3FF;
            else if (i % 20 == 1) re = '0;
            else                  re = EW'($urandom_range(0, 1023));
            run_op(rb, re, rm, -1, 1'b0);
            $display("rand%0d: base=%0d exp=%0d mod=%0d -> result=%0d latency=%0d",
                     i, rb, re, rm, g_res, g_lat);
            check($sformatf("rand%0d_result", i), g_res, modpow(rb, re, rm));
            check($sformatf("rand%0d_latency", i), g_lat, exp_lat(re));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
